// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: TCDM slave terminating one crossbar output port; owns a
// single-port, word-organised, byte-writable memory bank.
// Latency: gnt after WAIT_CYCLES cycles (combinational when 0); response one cycle after gnt.
// Backpressure: gnt_o withheld until the wait sequence completes; the master holds the request stable.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, add_i, wen_i     request valid, full byte address, 1=read / 0=write
//   wdata_i, be_i           write data and byte enables
//   gnt_o                   request accepted in this cycle
//   r_valid_o, r_rdata_o    registered response valid and read data
//   r_opc_o                 1 = access fell outside this bank's region
//   err_cnt_o               saturating count of errored grants

module tcdm_bank_responder #(
   parameter int unsigned NR_BANKS    = 4,
   parameter int unsigned NUM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] add_i,
   input  logic        wen_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic        gnt_o,
   output logic        r_valid_o,
   output logic [31:0] r_rdata_o,
   output logic        r_opc_o,
   output logic [15:0] err_cnt_o
);

   localparam int unsigned SEL_W   = $clog2(NR_BANKS);
   localparam int unsigned ROW_W   = $clog2(NUM_WORDS);
   localparam int unsigned ROW_LSB = SEL_W + 2;
   localparam int unsigned TAG_LSB = ROW_LSB + ROW_W;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (NR_BANKS == 0 || (NR_BANKS & (NR_BANKS - 1)) != 0) begin : g_chk_banks
      $error("tcdm_bank_responder: NR_BANKS must be a power of two");
   end
   if (NUM_WORDS == 0 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_chk_words
      $error("tcdm_bank_responder: NUM_WORDS must be a power of two");
   end
   if (WAIT_CYCLES > 15) begin : g_chk_wait
      $error("tcdm_bank_responder: WAIT_CYCLES must be in 0..15");
   end
   if (TAG_LSB > 31) begin : g_chk_region
      $error("tcdm_bank_responder: region too large for a 32-bit address");
   end

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   // Byte offset and bank-select bits are already consumed by the crossbar.
   logic                 unused_addr_bits;
   logic [ROW_W-1:0]     row;
   logic                 in_region;

   assign unused_addr_bits = ^add_i[ROW_LSB-1:0];
   assign row              = add_i[ROW_LSB +: ROW_W];
   assign in_region        = (add_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

   // ------------------------------------------------------------------
   // Wait-state FSM
   // ------------------------------------------------------------------
   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       grant;

   // gnt must be visible in the request cycle when WAIT_CYCLES=0, so it is
   // decoded from the registered state and the live req_i rather than
   // registered itself. rst_i gates it so a write in the reset cycle is dropped.
   always_comb begin
      grant = 1'b0;
      if (!rst_i && req_i) begin
         if (WAIT_CYCLES == 0) begin
            grant = 1'b1;
         end else if (state == ST_WAIT && wait_cnt == WAIT_CNT) begin
            grant = 1'b1;
         end
      end
   end

   assign gnt_o = grant;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               // With no wait states every request is granted from IDLE.
               if (req_i && WAIT_CYCLES != 0) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 4'd1;
               end
            end
            ST_WAIT: begin
               if (!req_i) begin
                  // Master withdrew the request: abandon it without a response.
                  state    <= ST_IDLE;
                  wait_cnt <= 4'd0;
               end else if (wait_cnt == WAIT_CNT) begin
                  // Granted this cycle; a held req restarts the sequence next cycle.
                  state    <= ST_IDLE;
                  wait_cnt <= 4'd0;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               wait_cnt <= 4'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Memory bank (contents are not reset)
   // ------------------------------------------------------------------
   logic [31:0] mem [NUM_WORDS];
   logic        do_write;
   logic        do_read;

   assign do_write = grant && in_region && !wen_i;
   assign do_read  = grant && in_region &&  wen_i;

   always_ff @(posedge clk_i) begin
      if (do_write) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem[row][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response and error counter
   // ------------------------------------------------------------------
   // A read and a write never share a grant, so mem[row] here is the
   // pre-access value; a write on the previous grant has already landed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_o <= 1'b0;
         r_rdata_o <= 32'd0;
         r_opc_o   <= 1'b0;
      end else begin
         r_valid_o <= grant;
         r_opc_o   <= grant && !in_region;
         r_rdata_o <= do_read ? mem[row] : 32'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_cnt_o <= 16'd0;
      end else if (grant && !in_region && err_cnt_o != 16'hFFFF) begin
         err_cnt_o <= err_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb_tcdm_bank_responder: directed bench for tcdm_bank_responder with three
// instances (WAIT_CYCLES = 0, 3, 2). Inputs change on the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.

module tb_tcdm_bank_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // WAIT_CYCLES = 0 instance
   logic        rst0, req0, wen0, gnt0, rv0, opc0;
   logic [31:0] add0, wd0, rd0;
   logic [3:0]  be0;
   logic [15:0] ec0;
   // WAIT_CYCLES = 3 instance
   logic        rst3, req3, wen3, gnt3, rv3, opc3;
   logic [31:0] add3, wd3, rd3;
   logic [3:0]  be3;
   logic [15:0] ec3;
   // WAIT_CYCLES = 2 instance
   logic        rst2, req2, wen2, gnt2, rv2, opc2;
   logic [31:0] add2, wd2, rd2;
   logic [3:0]  be2;
   logic [15:0] ec2;

   tcdm_bank_responder #(.NR_BANKS(4), .NUM_WORDS(1024), .BASE_ADDR(32'h1C00_0000), .WAIT_CYCLES(0)) u_w0 (
      .clk_i(clk), .rst_i(rst0), .req_i(req0), .add_i(add0), .wen_i(wen0), .wdata_i(wd0), .be_i(be0),
      .gnt_o(gnt0), .r_valid_o(rv0), .r_rdata_o(rd0), .r_opc_o(opc0), .err_cnt_o(ec0));

   tcdm_bank_responder #(.NR_BANKS(4), .NUM_WORDS(1024), .BASE_ADDR(32'h1C00_0000), .WAIT_CYCLES(3)) u_w3 (
      .clk_i(clk), .rst_i(rst3), .req_i(req3), .add_i(add3), .wen_i(wen3), .wdata_i(wd3), .be_i(be3),
      .gnt_o(gnt3), .r_valid_o(rv3), .r_rdata_o(rd3), .r_opc_o(opc3), .err_cnt_o(ec3));

   tcdm_bank_responder #(.NR_BANKS(4), .NUM_WORDS(1024), .BASE_ADDR(32'h1C00_0000), .WAIT_CYCLES(2)) u_w2 (
      .clk_i(clk), .rst_i(rst2), .req_i(req2), .add_i(add2), .wen_i(wen2), .wdata_i(wd2), .be_i(be2),
      .gnt_o(gnt2), .r_valid_o(rv2), .r_rdata_o(rd2), .r_opc_o(opc2), .err_cnt_o(ec2));

   // Drive helpers (stimulus only)
   task automatic drv0(input logic rq, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req0 = rq; wen0 = rd; add0 = a; wd0 = d; be0 = b;
   endtask

   task automatic drv3(input logic rq, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req3 = rq; wen3 = rd; add3 = a; wd3 = d; be3 = b;
   endtask

   task automatic drv2(input logic rq, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req2 = rq; wen2 = rd; add2 = a; wd2 = d; be2 = b;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
      drv0(1'b1, 1'b0, 32'h1C00_0010, 32'hFFFF_FFFF, 4'hF);
      drv3(1'b1, 1'b0, 32'h1C00_0010, 32'hFFFF_FFFF, 4'hF);
      drv2(1'b1, 1'b0, 32'h1C00_0010, 32'hFFFF_FFFF, 4'hF);
      #1;
      checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL rst_gnt_w0: got %b want 0", gnt0); end
      checks++; if (gnt3 !== 1'b0) begin failures++; $display("FAIL rst_gnt_w3: got %b want 0", gnt3); end
      checks++; if (gnt2 !== 1'b0) begin failures++; $display("FAIL rst_gnt_w2: got %b want 0", gnt2); end
      @(negedge clk); #1;
      checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL rst_rvalid_w0: got %b want 0", rv0); end
      checks++; if (rd0 !== 32'd0) begin failures++; $display("FAIL rst_rdata_w0: got %h want 0", rd0); end
      checks++; if (opc0 !== 1'b0) begin failures++; $display("FAIL rst_opc_w0: got %b want 0", opc0); end
      checks++; if (ec0 !== 16'd0) begin failures++; $display("FAIL rst_errcnt_w0: got %h want 0", ec0); end
      checks++; if (rv3 !== 1'b0 || rv2 !== 1'b0) begin failures++; $display("FAIL rst_rvalid_w3w2: got %b %b want 0 0", rv3, rv2); end
      @(negedge clk);
      rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
      req0 = 1'b0; req3 = 1'b0; req2 = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_basic_rw();
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF);
      #1;
      checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL basic_wr_gnt: got %b want 1", gnt0); end
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h1C00_0010, 32'h0, 4'h0);
      #1;
      checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL basic_rd_gnt: got %b want 1", gnt0); end
      checks++; if ({rv0, opc0, rd0} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL basic_wr_rsp: got v=%b o=%b d=%h want v=1 o=0 d=0", rv0, opc0, rd0); end
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if ({rv0, opc0, rd0} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin failures++; $display("FAIL basic_rd_rsp: got v=%b o=%b d=%h want v=1 o=0 d=deadbeef", rv0, opc0, rd0); end
      @(negedge clk); #1;
      checks++; if ({rv0, opc0, rd0} !== {1'b0, 1'b0, 32'd0}) begin failures++; $display("FAIL basic_idle_rsp: got v=%b o=%b d=%h want all 0", rv0, opc0, rd0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_partial_write();
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h1C00_0010, 32'h1122_3344, 4'b0101);
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h1C00_0010, 32'h0, 4'h0);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if (rd0 !== 32'hDE22_BE44) begin failures++; $display("FAIL partial_wr: got %h want de22be44", rd0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_read_after_write();
      logic [31:0] vals [2];
      vals[0] = 32'hCAFE_F00D;
      vals[1] = 32'h0BAD_0BAD;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drv0(1'b1, 1'b0, 32'h1C00_0050, vals[i], 4'hF);
         @(negedge clk);
         drv0(1'b1, 1'b1, 32'h1C00_0050, 32'h0, 4'h0);
         #1;
         checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL raw_rd_gnt[%0d]: got %b want 1", i, gnt0); end
         @(negedge clk);
         req0 = 1'b0;
         #1;
         checks++; if ({rv0, rd0} !== {1'b1, vals[i]}) begin failures++; $display("FAIL raw_rd_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rv0, rd0, vals[i]); end
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_error();
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h1C00_0000, 32'h1234_5678, 4'hF);
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
      #1;
      checks++; if (opc0 !== 1'b0) begin failures++; $display("FAIL err_ok_opc: got %b want 0", opc0); end
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'h0);
      #1;
      checks++; if ({rv0, opc0, rd0} !== {1'b1, 1'b1, 32'd0}) begin failures++; $display("FAIL err_wr_rsp: got v=%b o=%b d=%h want v=1 o=1 d=0", rv0, opc0, rd0); end
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
      #1;
      checks++; if ({rv0, opc0, rd0} !== {1'b1, 1'b1, 32'd0}) begin failures++; $display("FAIL err_rd_rsp: got v=%b o=%b d=%h want v=1 o=1 d=0", rv0, opc0, rd0); end
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h1C00_0000, 32'h0, 4'h0);
      #1;
      checks++; if (ec0 !== 16'd3) begin failures++; $display("FAIL err_cnt3: got %0d want 3", ec0); end
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if ({opc0, rd0} !== {1'b0, 32'h1234_5678}) begin failures++; $display("FAIL err_mem_untouched: got o=%b d=%h want o=0 d=12345678", opc0, rd0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_err_saturation();
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'h0);
      repeat (65531) @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if (ec0 !== 16'hFFFE) begin failures++; $display("FAIL sat_pre: got %h want fffe", ec0); end
      @(negedge clk);
      req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if (ec0 !== 16'hFFFF) begin failures++; $display("FAIL sat_reach: got %h want ffff", ec0); end
      @(negedge clk);
      req0 = 1'b1;
      repeat (4468) @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if (ec0 !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h want ffff", ec0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_write_w0();
      @(negedge clk);
      drv0(1'b1, 1'b0, 32'h1C00_0070, 32'h0000_0000, 4'hF);
      @(negedge clk);
      rst0 = 1'b1;
      drv0(1'b1, 1'b0, 32'h1C00_0070, 32'hFFFF_FFFF, 4'hF);
      #1;
      checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL rstwr_gnt: got %b want 0", gnt0); end
      @(negedge clk);
      rst0 = 1'b0;
      req0 = 1'b0;
      #1;
      checks++; if ({rv0, opc0, rd0, ec0} !== {1'b0, 1'b0, 32'd0, 16'd0}) begin failures++; $display("FAIL rstwr_outs: got v=%b o=%b d=%h e=%h want all 0", rv0, opc0, rd0, ec0); end
      @(negedge clk);
      drv0(1'b1, 1'b1, 32'h1C00_0070, 32'h0, 4'h0);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++; if ({rv0, rd0} !== {1'b1, 32'd0}) begin failures++; $display("FAIL rstwr_mem: got v=%b d=%h want v=1 d=0", rv0, rd0); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_wait3_back_to_back();
      logic exp_g;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) drv3(1'b1, 1'b0, 32'h1C00_0020, 32'hA5A5_5A5A, 4'hF);
         if (c == 5) drv3(1'b1, 1'b1, 32'h1C00_0020, 32'h0, 4'h0);
         #1;
         exp_g = (c == 4 || c == 8);
         checks++; if (gnt3 !== exp_g) begin failures++; $display("FAIL w3_gnt_c%0d: got %b want %b", c, gnt3, exp_g); end
         if (c == 4) begin
            checks++; if (rv3 !== 1'b0) begin failures++; $display("FAIL w3_rvalid_early: got %b want 0", rv3); end
         end
         if (c == 5) begin
            checks++; if ({rv3, opc3, rd3} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL w3_wr_rsp: got v=%b o=%b d=%h want v=1 o=0 d=0", rv3, opc3, rd3); end
         end
      end
      @(negedge clk);
      req3 = 1'b0;
      #1;
      checks++; if ({rv3, rd3} !== {1'b1, 32'hA5A5_5A5A}) begin failures++; $display("FAIL w3_rd_rsp: got v=%b d=%h want v=1 d=a5a55a5a", rv3, rd3); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_wait2_req_drop();
      @(negedge clk);
      drv2(1'b1, 1'b0, 32'h1C00_0030, 32'h5555_AAAA, 4'hF);
      @(negedge clk);
      req2 = 1'b0;
      #1;
      checks++; if (gnt2 !== 1'b0) begin failures++; $display("FAIL drop_gnt: got %b want 0", gnt2); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         req2 = 1'b1;
         #1;
         if (c == 1) begin
            checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL drop_no_rsp: got %b want 0", rv2); end
         end
         checks++; if (gnt2 !== (c == 3)) begin failures++; $display("FAIL drop_regnt_c%0d: got %b want %b", c, gnt2, (c == 3)); end
      end
      @(negedge clk);
      req2 = 1'b0;
      #1;
      checks++; if ({rv2, opc2, rd2} !== {1'b1, 1'b0, 32'd0}) begin failures++; $display("FAIL drop_rsp: got v=%b o=%b d=%h want v=1 o=0 d=0", rv2, opc2, rd2); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_wait2_reset();
      // reset while waiting: the wait restarts from scratch
      @(negedge clk);
      drv2(1'b1, 1'b0, 32'h1C00_0030, 32'h0F0F_0F0F, 4'hF);
      @(negedge clk);
      rst2 = 1'b1;
      #1;
      checks++; if (gnt2 !== 1'b0) begin failures++; $display("FAIL rstwait_gnt: got %b want 0", gnt2); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         rst2 = 1'b0;
         #1;
         checks++; if (gnt2 !== (c == 3)) begin failures++; $display("FAIL rstwait_regnt_c%0d: got %b want %b", c, gnt2, (c == 3)); end
         if (c == 1) begin
            checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL rstwait_rvalid: got %b want 0", rv2); end
         end
      end
      // reset in the cycle after a grant
      @(negedge clk);
      rst2 = 1'b1;
      #1;
      checks++; if (gnt2 !== 1'b0) begin failures++; $display("FAIL rstpost_gnt: got %b want 0", gnt2); end
      @(negedge clk);
      rst2 = 1'b0;
      req2 = 1'b0;
      #1;
      checks++; if ({gnt2, rv2, opc2, rd2} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin failures++; $display("FAIL rstpost_outs: got g=%b v=%b o=%b d=%h want all 0", gnt2, rv2, opc2, rd2); end
   endtask

   // ------------------------------------------------------------------
   initial begin
      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
      drv0(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      drv3(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      drv2(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      test_reset();
      test_basic_rw();
      test_partial_write();
      test_read_after_write();
      test_error();
      test_err_saturation();
      test_reset_write_w0();
      test_wait3_back_to_back();
      test_wait2_req_drop();
      test_wait2_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- TCDM slave endpoint terminating one output port of the interleaved L2 crossbar.
- Owns a single-port word-organised memory bank and accepts req/add/wen/wdata/be.
- Grants after a configurable number of wait states and returns r_valid/r_rdata/r_opc exactly one cycle after grant, for both reads and writes.
- Flags out-of-region accesses through r_opc and a saturating error counter.

Parameters:
NR_BANKS, 4, number of interleaved banks behind the crossbar; power of two; SEL_W = log2(NR_BANKS)
NUM_WORDS, 1024, 32-bit words in this bank; power of two; ROW_W = log2(NUM_WORDS)
BASE_ADDR, 32'h1C00_0000, byte base of the interleaved region; aligned to 4*NR_BANKS*NUM_WORDS
WAIT_CYCLES, 0, stall cycles inserted before gnt (0..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  1  request valid
add_i  in  32  byte address (full, not bank-local)
wen_i  in  1  1 = read, 0 = write
wdata_i  in  32  write data
be_i  in  4  byte enables for writes
gnt_o  out  1  request accepted this cycle
r_valid_o  out  1  response valid
r_rdata_o  out  32  read data
r_opc_o  out  1  1 = error (out of region)
err_cnt_o  out  16  saturating count of errored accesses

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Address decode:
  - add_i[1:0] ignored; add_i[SEL_W+1:2] is the bank select, ignored here because the crossbar has already routed.
  - row = add_i[SEL_W+2 +: ROW_W].
  - In region iff add_i[31:SEL_W+2+ROW_W] == BASE_ADDR[31:SEL_W+2+ROW_W].
- FSM states: IDLE, WAIT.
  - WAIT_CYCLES=0: FSM stays in IDLE; gnt_o = req_i combinationally.
  - WAIT_CYCLES>0, IDLE with req_i=1: gnt_o=0, wait counter loaded to 1, go to WAIT.
  - In WAIT: counter increments each cycle. gnt_o=1 in the cycle where counter==WAIT_CYCLES and req_i=1, then return to IDLE.
  - Result: first gnt occurs WAIT_CYCLES cycles after req rises.
  - req_i dropped in WAIT (protocol violation): return to IDLE, counter cleared, no access, no response.
  - Back-to-back: when req_i stays high after a grant, the next request restarts the wait sequence in the following cycle. With WAIT_CYCLES=0, one grant per cycle.
- Master obligation: add/wen/wdata/be held stable from req rise until gnt. The bank samples them only in the gnt cycle.
- Access in gnt cycle:
  - Write, in region: mem[row] byte k updated from wdata_i[8k+7:8k] iff be_i[k]. be_i=0 is a legal no-op write.
  - Read, in region: mem[row] captured.
  - Out of region: no memory update.
- Response, registered, the cycle after gnt:
  - r_valid_o=1.
  - Read OK: r_rdata_o = pre-access contents, r_opc_o=0.
  - Write OK: r_rdata_o=0, r_opc_o=0.
  - Error: r_rdata_o=0, r_opc_o=1.
  - r_valid_o is otherwise 0, and r_rdata_o/r_opc_o return to 0 when r_valid_o=0.
- Read-after-write to the same row on consecutive grants returns the newly written data (the write lands in the gnt cycle; the read samples a cycle later).
- err_cnt_o increments by 1 per errored grant and saturates at 16'hFFFF.
- Reset values: state IDLE, counter 0, gnt_o=0 (gated by rst_i, including WAIT_CYCLES=0), r_valid_o=0, r_rdata_o=0, r_opc_o=0, err_cnt_o=0. Memory contents are not reset.
- Reset mid-operation:
  - A pending WAIT is abandoned.
  - A response scheduled for the next cycle is suppressed.
  - A write granted in the same cycle as rst_i does not occur, because gnt is forced to 0.
- Elaboration errors: NR_BANKS or NUM_WORDS not a power of two; WAIT_CYCLES>15.

Test Plan:
- WAIT_CYCLES=0, BASE_ADDR=32'h1C00_0000: write add=32'h1C00_0010, wdata=32'hDEAD_BEEF, be=4'hF; then read the same address -> gnt in the req cycle each time; write rsp rdata=0, opc=0; read rsp next cycle rdata=32'hDEAD_BEEF.
- Partial write be=4'b0101, wdata=32'h1122_3344 onto 32'hDEAD_BEEF, then read -> 32'hDE22_BE44.
- WAIT_CYCLES=3: req held 4 cycles -> gnt only in the 4th cycle (3 cycles after req rise); r_valid in the 5th; back-to-back second request granted 4 cycles after the first gnt.
- Access add=32'h2000_0000 -> r_opc=1, r_rdata=0, memory unchanged; repeat 3 times -> err_cnt_o=3; force 70000 errors -> err_cnt_o stays 16'hFFFF.
- WAIT_CYCLES=2: assert rst_i during WAIT, and separately in the cycle after a gnt -> no gnt, no r_valid, outputs 0 in the following cycle; req drop in WAIT -> no response, next req waits the full 2 cycles.
- Read-after-write on consecutive cycles to row 5 with WAIT_CYCLES=0 -> read returns the new data with no stall.
